// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU: round-robin on ties,
// one operation in flight, result held for the owner until it is accepted.
package alu_arbiter_pkg;

  typedef enum logic [3:0] {
    kNOP  = 4'd0,
    kADDU = 4'd1,
    kSUBU = 4'd2,
    kXOR  = 4'd3,
    kAND  = 4'd4,
    kOR   = 4'd5,
    kBEQZ = 4'd6,
    kBNEZ = 4'd7
  } alu_opcode_e;

  typedef struct packed {
    alu_opcode_e opcode;
  } instruction_s;

endpackage

// state | meaning
// IDLE  | nothing in flight, arbitrate every cycle
// EXEC  | operands driven to the ALU, counter runs down to capture
// RESP  | result held for the owner; arbitrate on the owner's handshake
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [1:0][31:0]   req_rd_i,
  input  logic [1:0][31:0]   req_rs_i,
  input  instruction_s [1:0] req_op_i,
  output logic [31:0]        alu_rd_o,
  output logic [31:0]        alu_rs_o,
  output instruction_s       alu_op_o,
  input  logic [31:0]        alu_result_i,
  input  logic               alu_jump_now_i,
  output logic [1:0]         rsp_valid_o,
  input  logic [1:0]         rsp_ready_i,
  output logic [31:0]        rsp_result_o,
  output logic               rsp_jump_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_e       state, state_d;
  logic         last_grant;
  logic         owner;
  logic [3:0]   cnt;
  logic [31:0]  opnd_rd, opnd_rs;
  instruction_s opnd_op;
  logic [31:0]  res_result;
  logic         res_jump;

  logic grant;
  logic rsp_hs;
  logic arb_en;
  logic accept;

  always_comb begin
    grant   = req_valid_i[1];
    if (&req_valid_i) grant = ~last_grant;
    rsp_hs  = (state == S_RESP) && rsp_ready_i[owner];
    // gating with n_reset keeps the combinational ready low while in reset
    arb_en  = n_reset && ((state == S_IDLE) || rsp_hs);
    accept  = arb_en && (|req_valid_i);

    req_ready_o = 2'b00;
    if (accept) req_ready_o[grant] = 1'b1;

    state_d = state;
    case (state)
      S_IDLE: if (accept) state_d = S_EXEC;
      S_EXEC: if (cnt == 4'd0) state_d = S_RESP;
      S_RESP: if (rsp_hs) state_d = accept ? S_EXEC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= 4'd0;
      opnd_rd    <= '0;
      opnd_rs    <= '0;
      opnd_op    <= '0;
      res_result <= '0;
      res_jump   <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        opnd_rd    <= req_rd_i[grant];
        opnd_rs    <= req_rs_i[grant];
        opnd_op    <= req_op_i[grant];
        owner      <= grant;
        last_grant <= grant;
        cnt        <= CNT_LOAD;
      end else if (state == S_EXEC) begin
        if (cnt == 4'd0) begin
          res_result <= alu_result_i;
          res_jump   <= alu_jump_now_i;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

  always_comb begin
    alu_rd_o = '0;
    alu_rs_o = '0;
    alu_op_o = '0;
    if (state == S_EXEC) begin
      alu_rd_o = opnd_rd;
      alu_rs_o = opnd_rs;
      alu_op_o = opnd_op;
    end
    rsp_valid_o = 2'b00;
    if (state == S_RESP) rsp_valid_o[owner] = 1'b1;
  end

  assign rsp_result_o = res_result;
  assign rsp_jump_o   = res_jump;
  assign busy_o       = (state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, each cycle
// compared against a transaction-level model timed by cycle counts.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int E = 3;

  logic               clk;
  logic               n_reset;
  logic [1:0]         req_valid_i;
  logic [1:0]         req_ready_o;
  logic [1:0][31:0]   req_rd_i;
  logic [1:0][31:0]   req_rs_i;
  instruction_s [1:0] req_op_i;
  logic [31:0]        alu_rd_o;
  logic [31:0]        alu_rs_o;
  instruction_s       alu_op_o;
  logic [31:0]        alu_result_i;
  logic               alu_jump_now_i;
  logic [1:0]         rsp_valid_o;
  logic [1:0]         rsp_ready_i;
  logic [31:0]        rsp_result_o;
  logic               rsp_jump_o;
  logic               busy_o;

  alu_arbiter #(.EXEC_CYCLES(E)) dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rd_i(req_rd_i), .req_rs_i(req_rs_i), .req_op_i(req_op_i),
    .alu_rd_o(alu_rd_o), .alu_rs_o(alu_rs_o), .alu_op_o(alu_op_o),
    .alu_result_i(alu_result_i), .alu_jump_now_i(alu_jump_now_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o), .rsp_jump_o(rsp_jump_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural ALU: {jump, result}
  function automatic logic [32:0] alu_fn(alu_opcode_e op, logic [31:0] a, logic [31:0] b);
    case (op)
      kADDU:   return {1'b0, a + b};
      kSUBU:   return {1'b0, a - b};
      kXOR:    return {1'b0, a ^ b};
      kAND:    return {1'b0, a & b};
      kOR:     return {1'b0, a | b};
      kBEQZ:   return {(a == 32'd0), a};
      kBNEZ:   return {(a != 32'd0), a};
      default: return 33'd0;
    endcase
  endfunction

  assign {alu_jump_now_i, alu_result_i} = alu_fn(alu_op_o.opcode, alu_rd_o, alu_rs_o);

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model: one transaction, phase derived from cycles since accept
  bit          m_busy;
  bit          m_owner;
  bit          m_last;
  int          m_tacc;
  alu_opcode_e m_op;
  logic [31:0] m_rd, m_rs;
  logic [32:0] m_exp;
  logic [32:0] m_hold;

  int          log_owner[$];
  logic [32:0] log_res[$];

  alu_opcode_e ops[7] = '{kADDU, kSUBU, kXOR, kAND, kOR, kBEQZ, kBNEZ};

  task automatic chk(string tag, logic [32:0] obs, logic [32:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_busy  = 1'b0;
    m_owner = 1'b0;
    m_last  = 1'b1;
    m_hold  = '0;
  endtask

  task automatic set_req(int i, alu_opcode_e op, logic [31:0] rd, logic [31:0] rs);
    req_valid_i[i]     = 1'b1;
    req_op_i[i].opcode = op;
    req_rd_i[i]        = rd;
    req_rs_i[i]        = rs;
  endtask

  // check this cycle, advance the model, then step to just after the next edge
  task automatic tick();
    bit         in_resp, in_exec, hs, g;
    logic [1:0] exp_ready, seen_ready;
    @(negedge clk);
    in_resp   = m_busy && (cyc >= m_tacc + E + 1);
    in_exec   = m_busy && !in_resp;
    hs        = in_resp && rsp_ready_i[m_owner];
    g         = (req_valid_i == 2'b11) ? !m_last : req_valid_i[1];
    exp_ready = ((!m_busy || hs) && req_valid_i != 2'b00) ? (2'b01 << g) : 2'b00;
    seen_ready = req_ready_o;

    chk("busy", 33'(busy_o), 33'(m_busy));
    chk("req_ready", 33'(req_ready_o), 33'(exp_ready));
    chk("rsp_valid", 33'(rsp_valid_o), in_resp ? 33'(2'b01 << m_owner) : 33'd0);
    chk("rsp_data", {rsp_jump_o, rsp_result_o}, in_resp ? m_exp : m_hold);
    chk("alu_op", 33'(alu_op_o.opcode), in_exec ? 33'(m_op) : 33'd0);
    chk("alu_rd", 33'(alu_rd_o), in_exec ? 33'(m_rd) : 33'd0);
    chk("alu_rs", 33'(alu_rs_o), in_exec ? 33'(m_rs) : 33'd0);

    if (hs) begin
      log_owner.push_back(int'(m_owner));
      log_res.push_back(m_exp);
      m_busy = 1'b0;
      m_hold = m_exp;
    end
    if (exp_ready != 2'b00) begin
      m_busy  = 1'b1;
      m_owner = g;
      m_last  = g;
      m_tacc  = cyc;
      m_op    = req_op_i[g].opcode;
      m_rd    = req_rd_i[g];
      m_rs    = req_rs_i[g];
      m_exp   = alu_fn(m_op, m_rd, m_rs);
    end
    cyc++;
    @(posedge clk);
    #1;
    if (seen_ready[0]) req_valid_i[0] = 1'b0;
    if (seen_ready[1]) req_valid_i[1] = 1'b0;
  endtask

  initial begin
    n_reset     = 1'b0;
    req_valid_i = 2'b00;
    req_rd_i    = '0;
    req_rs_i    = '0;
    req_op_i    = '0;
    rsp_ready_i = 2'b00;
    reset_model();

    #3;
    req_valid_i = 2'b11;
    #1;
    chk("rst_ready", 33'(req_ready_o), 33'd0);
    chk("rst_busy", 33'(busy_o), 33'd0);
    chk("rst_rsp_valid", 33'(rsp_valid_o), 33'd0);
    chk("rst_rsp_data", {rsp_jump_o, rsp_result_o}, 33'd0);
    chk("rst_alu_op", 33'(alu_op_o), 33'd0);
    req_valid_i = 2'b00;
    @(posedge clk);
    #1;
    n_reset = 1'b1;

    // tie after reset: req0 first, req1 on its handshake, then req0 again
    rsp_ready_i = 2'b11;
    set_req(0, kSUBU, 32'd10, 32'd3);
    set_req(1, kXOR, 32'hF0, 32'h0F);
    repeat (E + 2) tick();
    set_req(0, kADDU, 32'd1, 32'd2);
    set_req(1, kOR, 32'd3, 32'd4);
    repeat (2 * (E + 1) + 4) tick();
    chk("tie_log_size", 33'(log_res.size()), 33'd4);
    if (log_res.size() >= 4) begin
      chk("tie0_owner", 33'(log_owner[0]), 33'd0);
      chk("tie0_res", log_res[0], 33'd7);
      chk("tie1_owner", 33'(log_owner[1]), 33'd1);
      chk("tie1_res", log_res[1], 33'hFF);
      chk("tie2_owner", 33'(log_owner[2]), 33'd0);
      chk("tie2_res", log_res[2], 33'd3);
      chk("tie3_owner", 33'(log_owner[3]), 33'd1);
      chk("tie3_res", log_res[3], 33'd7);
    end

    // single request latency
    set_req(0, kADDU, 32'd5, 32'd7);
    tick();
    chk("lat_alu_op", 33'(alu_op_o.opcode), 33'(kADDU));
    repeat (E) tick();
    chk("lat_rsp_valid", 33'(rsp_valid_o), 33'b01);
    chk("lat_rsp_res", 33'(rsp_result_o), 33'd12);
    tick();

    // branch on requester 1, operands held for E cycles
    set_req(1, kBEQZ, 32'd0, 32'd9);
    tick();
    for (int k = 0; k < E; k++) begin
      chk("beqz_alu_op", 33'(alu_op_o.opcode), 33'(kBEQZ));
      tick();
    end
    chk("beqz_rsp_valid", 33'(rsp_valid_o), 33'b10);
    chk("beqz_jump", 33'(rsp_jump_o), 33'd1);
    tick();

    // owner stalls the response while the other side toggles its request
    rsp_ready_i = 2'b00;
    set_req(0, kAND, 32'hFF, 32'h0F);
    tick();
    repeat (E) tick();
    for (int k = 0; k < 5; k++) begin
      if (req_valid_i[1]) req_valid_i[1] = 1'b0;
      else set_req(1, ops[$urandom_range(0, 6)], $urandom, $urandom);
      tick();
      chk("stall_rsp_res", 33'(rsp_result_o), 33'h0F);
    end
    // only the non-owner acknowledges: no handshake
    rsp_ready_i = 2'b10;
    repeat (3) tick();
    chk("nonowner_rsp_valid", 33'(rsp_valid_o), 33'b01);
    chk("nonowner_busy", 33'(busy_o), 33'd1);
    rsp_ready_i = 2'b11;
    repeat (E + 4) tick();

    // reset in the middle of EXEC
    set_req(0, kADDU, 32'd1, 32'd1);
    tick();
    tick();
    n_reset = 1'b0;
    set_req(0, kXOR, 32'h5, 32'h3);
    set_req(1, kSUBU, 32'h9, 32'h4);
    #1;
    chk("mid_rst_ready", 33'(req_ready_o), 33'd0);
    chk("mid_rst_busy", 33'(busy_o), 33'd0);
    chk("mid_rst_rsp_valid", 33'(rsp_valid_o), 33'd0);
    chk("mid_rst_rsp_data", {rsp_jump_o, rsp_result_o}, 33'd0);
    chk("mid_rst_alu_op", 33'(alu_op_o), 33'd0);
    chk("mid_rst_alu_rd", 33'(alu_rd_o), 33'd0);
    #1;
    n_reset = 1'b1;
    reset_model();
    log_owner.delete();
    log_res.delete();
    tick();
    repeat (E + 1) tick();
    chk("post_rst_log_size", 33'(log_res.size()), 33'd1);
    if (log_res.size() >= 1) begin
      chk("post_rst_owner", 33'(log_owner[0]), 33'd0);
      chk("post_rst_res", log_res[0], 33'd6);
    end

    // random traffic
    for (int c = 0; c < 400; c++) begin
      rsp_ready_i = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (!req_valid_i[i] && $urandom_range(0, 2) == 0)
          set_req(i, ops[$urandom_range(0, 6)],
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, $urandom);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, number of cycles operands are held on the shared ALU before the result is captured; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 n_reset  input  1  reset, asynchronous and active-low.
REQ-004 req_valid_i  input  2  per-requester operation request; index 0 = core pipeline, index 1 = auxiliary requester.
REQ-005 req_ready_o  output  2  per-requester accept strobe, one-hot or zero.
REQ-006 req_rd_i / req_rs_i  input  2x32  per-requester operands.
REQ-007 req_op_i  input  2 x instruction_s  per-requester instruction.
REQ-008 alu_rd_o / alu_rs_o  output  32 each  operands driven to the shared ALU.
REQ-009 alu_op_o  output  instruction_s  instruction driven to the shared ALU.
REQ-010 alu_result_i  input  32  ALU result; alu_jump_now_i  input  1  ALU branch-taken flag.
REQ-011 rsp_valid_o  output  2  per-requester response valid, one-hot or zero.
REQ-012 rsp_ready_i  input  2  per-requester response accept.
REQ-013 rsp_result_o  output  32; rsp_jump_o  output  1  captured result and branch flag, shared by both requesters, qualified by rsp_valid_o.
REQ-014 busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, RESP; exactly one operation in flight at a time.
REQ-016 Arbitration SHALL run in IDLE, and in RESP on the cycle its response handshake completes.
REQ-017 Arbitration: one valid -> grant it; both valid -> grant the index not equal to last_grant; last_grant SHALL update to the granted index on accept.
REQ-018 Accept: req_ready_o[g] high combinationally in the arbitration cycle; req_rd/rs/op of g latched into operand registers; owner <= g; counter <= EXEC_CYCLES-1; next state EXEC.
REQ-019 req_ready_o SHALL be zero in EXEC and in RESP without handshake; requesters hold inputs stable until ready.
REQ-020 EXEC: alu_* outputs driven from operand registers; counter decrements each cycle; at counter==0 alu_result_i and alu_jump_now_i captured into result registers, next state RESP.
REQ-021 Outside EXEC, alu_rd_o, alu_rs_o, alu_op_o SHALL be all-zero (NOP).
REQ-022 Latency: accept in cycle N -> rsp_valid_o[owner] high from cycle N+EXEC_CYCLES+1.
REQ-023 RESP: rsp_valid_o[owner] high, rsp_result_o/rsp_jump_o stable until rsp_ready_i[owner]; rsp_ready_i of the non-owner ignored.
REQ-024 RESP handshake with a pending valid request -> accept it in the same cycle, go directly to EXEC; no pending request -> IDLE.
REQ-025 Back-to-back throughput SHALL be one operation per EXEC_CYCLES+1 cycles.
REQ-026 rsp_result_o/rsp_jump_o hold last captured values outside RESP; rsp_valid_o zero outside RESP.

Reset
REQ-027 n_reset low SHALL asynchronously force: state IDLE, last_grant=1 (index 0 wins first tie), owner=0, counter=0, operand and result registers zero, all outputs zero.
REQ-028 Reset during EXEC or RESP SHALL abandon the operation; no response is issued after reset release.
REQ-029 First arbitration SHALL occur on the first rising edge with n_reset high.

Verification
REQ-030 EXEC_CYCLES=1, req 0 kADDU rd=5 rs=7 in cycle 0 -> ready_o=01 cycle 0, alu_op_o=kADDU cycle 1, rsp_valid_o=01 result=12 cycle 2.
REQ-031 Both valid after reset, req0 kSUBU 10,3, req1 kXOR 0xF0,0x0F, rsp_ready always 1 -> req0 served first (result 7), req1 accepted on the req0 handshake cycle (result 0xFF); then both again -> req0 wins.
REQ-032 EXEC_CYCLES=3, req1 kBEQZ rd=0 -> alu_op_o stable 3 cycles, rsp_valid_o=10 with rsp_jump_o=1 at accept+4.
REQ-033 rsp_ready_i[owner] held low 5 cycles, req_valid toggling -> rsp_valid/result stable, req_ready_o stays 00, alu_op_o NOP.
REQ-034 n_reset low mid-EXEC -> all outputs zero immediately; after release no rsp_valid_o; next tie goes to req0.
REQ-035 rsp_ready_i asserted only for the non-owner -> no handshake, state remains RESP.
